// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Grant-index width helper keeps single-requester builds legal.
package uart_arb_pkg;

  localparam int unsigned DefaultDataW = 8;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bus between the requesters, the arbiter and the UART.
// slave is the arbiter's view; master is the requester/UART side.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = DefaultDataW
);

  logic [N_REQ*DATA_W-1:0] s_tdata;
  logic [N_REQ-1:0]        s_tvalid;
  logic [N_REQ-1:0]        s_tlast;
  logic [N_REQ-1:0]        s_tready;
  logic [DATA_W-1:0]       m_tdata;
  logic                    m_tvalid;
  logic                    m_tready;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant, with wrap.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned GntW  = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GntW-1:0]  last_grant,
  output logic             any,
  output logic [GntW-1:0]  pick
);

  always_comb begin
    int unsigned idx;
    idx  = 0;
    any  = 1'b0;
    pick = '0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = (int'(last_grant) + off) % N_REQ;
      if (!any && req[idx]) begin
        any  = 1'b1;
        pick = idx[GntW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one UART byte stream among N_REQ
// requesters, with a one-entry registered output stage.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int unsigned N_REQ     = 4,
  parameter  int unsigned DATA_W    = DefaultDataW,
  parameter  int unsigned MAX_BURST = 16,
  localparam int unsigned GntW      = idx_w(N_REQ),
  localparam int unsigned CntW      = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus,
  output logic [GntW-1:0]    grant_id,
  output logic               busy,
  output logic               burst_cut
);

  localparam logic [CntW-1:0] CntMax = (MAX_BURST > 0) ? CntW'(MAX_BURST) : {CntW{1'b1}};

  arb_state_t        state_q, state_d;
  logic [GntW-1:0]   grant_q, grant_d;
  logic [GntW-1:0]   last_q, last_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mvalid_q, mvalid_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic              cut_q, cut_d;

  logic              any;
  logic [GntW-1:0]   pick;
  logic              out_ready;
  logic              accept;
  logic              sel_valid;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;
  logic [CntW-1:0]   cnt_next;
  logic              hit_burst;
  logic [N_REQ-1:0]  tready;

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req        (bus.s_tvalid),
    .last_grant (last_q),
    .any        (any),
    .pick       (pick)
  );

  // Output slot can take a byte when empty or draining this cycle.
  assign out_ready = !mvalid_q || bus.m_tready;
  assign sel_valid = bus.s_tvalid[grant_q];
  assign sel_last  = bus.s_tlast[grant_q];
  assign sel_data  = bus.s_tdata[int'(grant_q) * int'(DATA_W) +: DATA_W];
  assign accept    = (state_q == LOCK) && sel_valid && out_ready;
  assign cnt_next  = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
  assign hit_burst = (MAX_BURST != 0) && (cnt_next == CntMax);

  always_comb begin
    tready = '0;
    if (state_q == LOCK) tready[grant_q] = out_ready;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    cut_d    = 1'b0;
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;

    unique case (state_q)
      ARB: begin
        if (any) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = LOCK;
        end
      end
      LOCK: begin
        if (accept) begin
          cnt_d = cnt_next;
          if (sel_last || hit_burst) begin
            state_d = ARB;
            last_d  = grant_q;
            // tlast takes priority: a packet ending on the limit is not a cut.
            cut_d   = !sel_last;
          end
        end
      end
      default: state_d = ARB;
    endcase

    if (accept) begin
      mvalid_d = 1'b1;
      mdata_d  = sel_data;
    end else if (bus.m_tready) begin
      mvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB;
      grant_q  <= '0;
      last_q   <= GntW'(N_REQ - 1);
      cnt_q    <= '0;
      cut_q    <= 1'b0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      cut_q    <= cut_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
    end
  end

  assign bus.s_tready = tready;
  assign bus.m_tvalid = mvalid_q;
  assign bus.m_tdata  = mdata_q;
  assign grant_id     = grant_q;
  assign busy         = (state_q == LOCK);
  assign burst_cut    = cut_q;

endmodule
